// File: rtl/lcd_timing_gen.sv
// Parametrised LCD/VGA raster timing generator with lead-compensated pixel fetch strobe.
// Optional test-pattern source on lcd_rgb enabled by defining LCD_TEST_PATTERN_EN.
module lcd_timing_gen #(
    parameter int unsigned H_DISP   = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_DISP   = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned XY_W     = 11,
    parameter int unsigned REQ_LEAD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              lcd_dclk,
    output logic              lcd_blank,
    output logic              lcd_sync,
    output logic              lcd_hs,
    output logic              lcd_vs,
    output logic              lcd_en,
    output logic [DATA_W-1:0] lcd_rgb,
    output logic              lcd_request,
    output logic              lcd_framesync,
    output logic [XY_W-1:0]   lcd_xpos,
    output logic [XY_W-1:0]   lcd_ypos,
    input  logic [DATA_W-1:0] lcd_data
`ifdef LCD_TEST_PATTERN_EN
    ,
    input  logic [1:0]        test_mode
`endif
);

    localparam int unsigned CW      = XY_W + 1;
    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_DISP + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_DISP + V_FP;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam int unsigned XY_LIM  = 1 << XY_W;

    localparam logic [CW-1:0] H_MAX   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_MAX   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);
    localparam logic [CW-1:0] H_DS    = CW'(H_START);
    localparam logic [CW-1:0] H_DE    = CW'(H_START + H_DISP);
    localparam logic [CW-1:0] H_RS    = CW'(H_START - REQ_LEAD);
    localparam logic [CW-1:0] H_RE    = CW'(H_START + H_DISP - REQ_LEAD);
    localparam logic [CW-1:0] V_DS    = CW'(V_START);
    localparam logic [CW-1:0] V_DE    = CW'(V_START + V_DISP);
    localparam logic          HS_ACT  = (HS_POL != 0);
    localparam logic          VS_ACT  = (VS_POL != 0);

    if (REQ_LEAD > H_BP) begin : g_bad_lead
        $error("REQ_LEAD must not exceed H_BP");
    end
    if (H_TOTAL >= XY_LIM || V_TOTAL >= XY_LIM) begin : g_bad_total
        $error("H_TOTAL/V_TOTAL must be below 2**XY_W");
    end

    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_disp, h_req, v_disp;
    logic          hs_q, vs_q, en_q, req_q, fs_q;
    logic [XY_W-1:0] xpos_q, ypos_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_MAX) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + CW'(1);
        end else begin
            h_cnt <= h_cnt + CW'(1);
        end
    end

    always_comb begin
        h_disp = (h_cnt >= H_DS) && (h_cnt < H_DE);
        // Fetch window is the display window pulled REQ_LEAD clocks earlier, same line
        h_req  = (h_cnt >= H_RS) && (h_cnt < H_RE);
        v_disp = (v_cnt >= V_DS) && (v_cnt < V_DE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q   <= ~HS_ACT;
            vs_q   <= ~VS_ACT;
            en_q   <= 1'b0;
            req_q  <= 1'b0;
            fs_q   <= 1'b0;
            xpos_q <= '0;
            ypos_q <= '0;
        end else begin
            hs_q   <= (h_cnt < H_SYNC_C) ? HS_ACT : ~HS_ACT;
            vs_q   <= (v_cnt < V_SYNC_C) ? VS_ACT : ~VS_ACT;
            en_q   <= h_disp && v_disp;
            req_q  <= h_req && v_disp;
            fs_q   <= (h_cnt == '0) && (v_cnt == '0);
            xpos_q <= (h_req && v_disp) ? XY_W'(h_cnt - H_RS) : '0;
            ypos_q <= (h_req && v_disp) ? XY_W'(v_cnt - V_DS) : '0;
        end
    end

`ifdef LCD_TEST_PATTERN_EN
    // Coordinates of the pixel currently on the panel, aligned with en_q
    logic [XY_W-1:0] px_q, py_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q <= '0;
            py_q <= '0;
        end else begin
            px_q <= (h_disp && v_disp) ? XY_W'(h_cnt - H_DS) : '0;
            py_q <= (h_disp && v_disp) ? XY_W'(v_cnt - V_DS) : '0;
        end
    end

    always_comb begin
        lcd_rgb = '0;
        if (en_q) begin
            unique case (test_mode)
                2'd0: lcd_rgb = lcd_data;
                2'd1: lcd_rgb = DATA_W'(px_q);
                2'd2: lcd_rgb = (px_q[5] ^ py_q[5]) ? '1 : '0;
                2'd3: lcd_rgb = '1;
            endcase
        end
    end
`else
    always_comb begin
        lcd_rgb = en_q ? lcd_data : '0;
    end
`endif

    assign lcd_dclk      = ~clk;
    assign lcd_blank     = en_q;
    assign lcd_sync      = 1'b0;
    assign lcd_hs        = hs_q;
    assign lcd_vs        = vs_q;
    assign lcd_en        = en_q;
    assign lcd_request   = req_q;
    assign lcd_framesync = fs_q;
    assign lcd_xpos      = xpos_q;
    assign lcd_ypos      = ypos_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen: three instances (REQ_LEAD 1, 0, 3) on a 16x8 raster.
// Honours LCD_TEST_PATTERN_EN by switching the expected pixel source.
module tb_lcd_timing_gen;

    localparam int NI = 3;

    typedef struct {
        int          base;
        int          x;
        int          y;
        logic [15:0] rgb;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        dclk [NI];
    logic        blank[NI];
    logic        sync [NI];
    logic        hs   [NI];
    logic        vs   [NI];
    logic        en   [NI];
    logic        req  [NI];
    logic        fs   [NI];
    logic [15:0] rgb  [NI];
    logic [15:0] data [NI];
    logic [10:0] xpos [NI];
    logic [10:0] ypos [NI];
`ifdef LCD_TEST_PATTERN_EN
    logic [1:0]  tm = 2'd0;
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lead_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [15:0] d1, d2, d3;

        lcd_timing_gen #(
            .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
            .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
            .HS_POL(0), .VS_POL(0), .DATA_W(16), .XY_W(11),
            .REQ_LEAD((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .lcd_dclk     (dclk[g]),
            .lcd_blank    (blank[g]),
            .lcd_sync     (sync[g]),
            .lcd_hs       (hs[g]),
            .lcd_vs       (vs[g]),
            .lcd_en       (en[g]),
            .lcd_rgb      (rgb[g]),
            .lcd_request  (req[g]),
            .lcd_framesync(fs[g]),
            .lcd_xpos     (xpos[g]),
            .lcd_ypos     (ypos[g]),
            .lcd_data     (data[g])
`ifdef LCD_TEST_PATTERN_EN
            ,
            .test_mode    (tm)
`endif
        );

        // User-side memory model: returns {y,x} REQ_LEAD clocks after the request
        always @(posedge clk) begin
            d1 <= {ypos[g][7:0], xpos[g][7:0]};
            d2 <= d1;
            d3 <= d2;
        end
        assign data[g] = (g == 1) ? {ypos[g][7:0], xpos[g][7:0]} : ((g == 0) ? d1 : d3);
    end

    item_t exp_q[$];
    int    rd_req[NI];
    int    rd_en [NI];
    int    fs_cyc[NI];
    bit    have_fs[NI];
    bit    want_first[NI];
    int    rel_cyc = 0;
    int    n_vec = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input int i, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d", name, i, cyc, act, exp);
        end
    endtask

    task automatic push_frame(input int mode);
        item_t it;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                it.base = (3 + y) * 16 + 6 + x;
                it.x    = x;
                it.y    = y;
                case (mode)
                    1:       it.rgb = 16'(x);
                    3:       it.rgb = 16'hFFFF;
                    default: it.rgb = 16'(y * 256 + x);
                endcase
                exp_q.push_back(it);
            end
        end
    endtask

    task automatic sb_clear();
        exp_q.delete();
        for (int i = 0; i < NI; i++) begin
            rd_req[i]     = 0;
            rd_en[i]      = 0;
            have_fs[i]    = 1'b0;
            want_first[i] = 1'b0;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk({tag, "_hs"}, i, int'(hs[i]), 1);
            chk({tag, "_vs"}, i, int'(vs[i]), 1);
            chk({tag, "_en"}, i, int'(en[i]), 0);
            chk({tag, "_req"}, i, int'(req[i]), 0);
            chk({tag, "_fs"}, i, int'(fs[i]), 0);
            chk({tag, "_xpos"}, i, int'(xpos[i]), 0);
            chk({tag, "_ypos"}, i, int'(ypos[i]), 0);
            chk({tag, "_rgb"}, i, int'(rgb[i]), 0);
        end
    endtask

    // Monitor: frame-relative offset k indexes the raster; pops expectations on req/en
    initial begin
        item_t it;
        int    k;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("dclk", 0, int'(dclk[0]), 1);
                chk("sync", 0, int'(sync[0]), 0);
                for (int i = 0; i < NI; i++) begin
                    if (fs[i]) begin
                        if (want_first[i]) begin
                            chk("first_fs", i, cyc - rel_cyc, 1);
                            want_first[i] = 1'b0;
                        end
                        if (have_fs[i]) chk("fs_period", i, cyc - fs_cyc[i], 128);
                        fs_cyc[i]  = cyc;
                        have_fs[i] = 1'b1;
                    end
                    k = have_fs[i] ? (cyc - fs_cyc[i]) : -1;
                    if (have_fs[i]) begin
                        chk("hs", i, int'(hs[i]), ((k % 16) < 3) ? 0 : 1);
                        chk("vs", i, int'(vs[i]), (k < 32) ? 0 : 1);
                    end
                    if (req[i]) begin
                        if (rd_req[i] >= exp_q.size()) begin
                            chk("req_extra", i, rd_req[i], exp_q.size() - 1);
                        end else begin
                            it = exp_q[rd_req[i]];
                            rd_req[i]++;
                            chk("req_off", i, k, it.base - lead_of(i));
                            chk("xpos", i, int'(xpos[i]), it.x);
                            chk("ypos", i, int'(ypos[i]), it.y);
                        end
                    end else begin
                        chk("xpos_idle", i, int'(xpos[i]), 0);
                    end
                    if (en[i]) begin
                        if (rd_en[i] >= exp_q.size()) begin
                            chk("en_extra", i, rd_en[i], exp_q.size() - 1);
                        end else begin
                            it = exp_q[rd_en[i]];
                            rd_en[i]++;
                            chk("en_off", i, k, it.base);
                            chk("rgb", i, int'(rgb[i]), int'(it.rgb));
                            chk("blank", i, int'(blank[i]), 1);
                        end
                    end else begin
                        chk("rgb_idle", i, int'(rgb[i]), 0);
                        chk("blank_idle", i, int'(blank[i]), 0);
                    end
                end
            end
        end
    end

    initial begin
        int m1, m2;
`ifdef LCD_TEST_PATTERN_EN
        m1 = 1;
        m2 = 3;
`else
        m1 = 0;
        m2 = 0;
`endif
        sb_clear();
        repeat (3) @(negedge clk);
        chk_reset_vals("por");

        // Phase 1: two full frames, then reset mid-line at (h=10, v=4) of the third
        for (int f = 0; f < 3; f++) push_frame(m1);
`ifdef LCD_TEST_PATTERN_EN
        tm = 2'(m1);
`endif
        for (int i = 0; i < NI; i++) want_first[i] = 1'b1;
        rel_cyc = cyc;
        rst_n   = 1'b1;
        repeat (1 + 256 + 74) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");

        // Phase 2: restart from (0,0) and run two complete frames
        sb_clear();
        for (int f = 0; f < 2; f++) push_frame(m2);
`ifdef LCD_TEST_PATTERN_EN
        tm = 2'(m2);
`endif
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) want_first[i] = 1'b1;
        rel_cyc = cyc;
        rst_n   = 1'b1;
        repeat (1 + 256 + 10) @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("req_count", i, rd_req[i], 64);
            chk("en_count", i, rd_en[i], 64);
            chk("fs_seen", i, int'(have_fs[i]), 1);
            chk("first_fs_pending", i, int'(want_first[i]), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
Parametrised LCD/VGA raster timing engine. It generalises the fixed 640x480 display driver to any resolution, porch set, sync polarity, pixel width and fetch lead time. Sits between the SDRAM read FIFO (user side: request, coordinates, data) and the DAC/panel pins. Emits frame sync and pixel coordinates so upstream buffers can prefetch with a programmable latency.

Parameters:
H_DISP, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_DISP, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
DATA_W, 16, pixel data width
XY_W, 11, coordinate width
REQ_LEAD, 1, clocks between lcd_request and matching lcd_en; legal 0..H_BP

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
lcd_dclk  output  1  panel pixel clock, ~clk
lcd_blank  output  1  DAC BLANK_n, equals lcd_en
lcd_sync  output  1  DAC SYNC_n, tied 0
lcd_hs  output  1  horizontal sync, polarity HS_POL
lcd_vs  output  1  vertical sync, polarity VS_POL
lcd_en  output  1  display-enable window
lcd_rgb  output  DATA_W  pixel out
lcd_request  output  1  pixel fetch strobe
lcd_framesync  output  1  one-clock start-of-frame pulse
lcd_xpos  output  XY_W  column of requested pixel
lcd_ypos  output  XY_W  row of requested pixel
lcd_data  input  DATA_W  pixel from user
test_mode  input  2  present only with LCD_TEST_PATTERN_EN

Behaviour:
- H_TOTAL = H_SYNC+H_BP+H_DISP+H_FP; V_TOTAL = V_SYNC+V_BP+V_DISP+V_FP.
- h_cnt: 0..H_TOTAL-1, wraps to 0; v_cnt increments when h_cnt wraps, wraps at V_TOTAL-1 -> 0 together with h_cnt.
- Line order: sync [0,H_SYNC), back porch, display [H_START=H_SYNC+H_BP, H_START+H_DISP), front porch. Same for vertical.
- All outputs except lcd_dclk, lcd_sync, lcd_rgb are registered decodes of the previous cycle's counters (1-clock latency).
- lcd_hs active while h_cnt < H_SYNC; lcd_vs active while v_cnt < V_SYNC.
- lcd_en: h_cnt in display window AND v_cnt in display window.
- lcd_request: same as lcd_en with the horizontal window shifted REQ_LEAD earlier. It never crosses a line boundary. Exactly H_DISP requests per active line; REQ_LEAD=0 makes it identical to lcd_en.
- lcd_xpos = h_cnt-(H_START-REQ_LEAD) and lcd_ypos = v_cnt-V_START while request is high; both 0 otherwise.
- lcd_data is sampled REQ_LEAD clocks after its request, i.e. the cycle lcd_en is high. lcd_rgb = lcd_en ? lcd_data : 0 (combinational).
- lcd_framesync: high for one clock when the registered counter pair was (0,0).
- Reset (async, any time including mid-line): counters 0; lcd_hs = ~HS_POL; lcd_vs = ~VS_POL; lcd_en, lcd_request, lcd_framesync, xpos, ypos = 0. First framesync pulse is in the 1st clock after rst_n release; a new frame restarts from h=0,v=0.
- Elaboration error if REQ_LEAD > H_BP, or if H_TOTAL or V_TOTAL ≥ 2^XY_W... counters use XY_W+1 bits internally.

Optional Feature:
LCD_TEST_PATTERN_EN
- Defined: adds test_mode port. When lcd_en is high, lcd_rgb follows test_mode:
  - 0: lcd_data.
  - 1: horizontal ramp, x zero-extended/truncated to DATA_W.
  - 2: 32x32 checker, all-ones when x[5]^y[5] else 0.
  - 3: all-ones.
  - x,y are the coordinates of the pixel being displayed. lcd_request keeps running in every mode.
- Undefined: no port; lcd_rgb = lcd_en ? lcd_data : 0.

Test Plan:
Small params H_DISP=8,H_FP=2,H_SYNC=3,H_BP=3,V_DISP=4,V_FP=1,V_SYNC=2,V_BP=1,REQ_LEAD=1 -> framesync period 128 clocks; lcd_hs low 3 clocks per 16; lcd_vs low 32 clocks per frame.
Same config -> per active line, request high 8 clocks with xpos 0..7, starting clock 5 after line start. lcd_en high 8 clocks starting 1 clock later; 32 requests and 32 en cycles per frame, ypos 0..3.
Drive lcd_data = {ypos,xpos} delayed 1 clock -> lcd_rgb equals the matching coordinate each en cycle, 0 elsewhere.
REQ_LEAD=0 and REQ_LEAD=3 -> request/en offset exactly 0 and 3 clocks; xpos sequence unchanged.
Assert rst_n low mid-line (h=10,v=4) -> outputs at reset values immediately; framesync 1 clock after release; next framesync 128 clocks later.
With LCD_TEST_PATTERN_EN, test_mode=3 -> lcd_rgb 16'hFFFF on all 32 en cycles. test_mode=1 -> 0..7 per line.
